// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus for the sequential divider.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic [1:0]       err;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, err
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, err
   );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one subtract-and-restore step per clock, WIDTH steps.
// err[0] = divide-by-zero on last operation, err[1] = start ignored while busy (sticky).
module seq_divider #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave div_if
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dz_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             busy_q;
   logic             done_q;
   logic [1:0]       err_q;

   logic [WIDTH:0]   rem_shift_d;
   logic [WIDTH:0]   trial_d;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] q_d;

   // One restoring step: shift in next dividend bit, trial-subtract, keep or restore.
   always_comb begin
      rem_shift_d = {r_q, q_q[WIDTH-1]};
      trial_d     = rem_shift_d - {1'b0, dvs_q};
      if (trial_d[WIDTH]) begin
         r_d = rem_shift_d[WIDTH-1:0];
         q_d = {q_q[WIDTH-2:0], 1'b0};
      end else begin
         r_d = trial_d[WIDTH-1:0];
         q_d = {q_q[WIDTH-2:0], 1'b1};
      end
   end

   // Control FSM with registered results and status.
   // A zero divisor still passes through RUN for one cycle (with busy low) so
   // its result appears one edge after acceptance, like the normal path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         r_q         <= '0;
         q_q         <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         dz_q        <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               state_q <= S_IDLE;
               if (div_if.start) begin
                  r_q     <= '0;
                  q_q     <= div_if.dividend;
                  dvs_q   <= div_if.divisor;
                  err_q   <= '0;
                  state_q <= S_RUN;
                  if (div_if.divisor == '0) begin
                     dz_q  <= 1'b1;
                     cnt_q <= '0;
                  end else begin
                     dz_q   <= 1'b0;
                     cnt_q  <= CNT_W'(WIDTH);
                     busy_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (div_if.start) begin
                  err_q[1] <= 1'b1;
               end
               if (dz_q) begin
                  quotient_q  <= '1;
                  remainder_q <= q_q;
                  err_q[0]    <= 1'b1;
                  dz_q        <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  r_q   <= r_d;
                  q_q   <= q_d;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     quotient_q  <= q_d;
                     remainder_q <= r_d;
                     err_q[0]    <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= S_DONE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign div_if.quotient  = quotient_q;
   assign div_if.remainder = remainder_q;
   assign div_if.busy      = busy_q;
   assign div_if.done      = done_q;
   assign div_if.err       = err_q;

endmodule
